// File: rtl/pn_transition_sequencer_pkg.sv
// Shared constants and helpers for the Petri-net transition sequencer.
// Holds default sizes, the index-width helper, the PRE/POST row extractor
// and the reference net used by the bench.
package pn_seq_pkg;

  localparam int N_T_DEF = 8;
  localparam int N_P_DEF = 10;

  // Upper bounds for the row extractor; nets beyond this need wider limits.
  localparam int MAX_T    = 64;
  localparam int MAX_P    = 64;
  localparam int MAX_BITS = MAX_T * MAX_P;

  // Width of an index into n items, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Pull row i (np bits starting at i*np) out of a flattened PRE/POST vector.
  function automatic logic [MAX_P-1:0] row_of(input logic [MAX_BITS-1:0] v,
                                              input int i, input int np);
    logic [MAX_P-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_P; b++)
      if (b < np && (i * np + b) < MAX_BITS) r[b] = v[i * np + b];
    return r;
  endfunction

  // Reference net: T0 p0->p1, T1 p0->p2, T2 p1->p0, T3 p2->p0,
  // T4 p3->p4, T5 p4->p3, T6/T7 have no preset. Rows listed T7..T0.
  localparam logic [N_T_DEF*N_P_DEF-1:0] BENCH_PRE = {
    10'h000, 10'h000, 10'h010, 10'h008, 10'h004, 10'h002, 10'h001, 10'h001};
  localparam logic [N_T_DEF*N_P_DEF-1:0] BENCH_POST = {
    10'h000, 10'h000, 10'h008, 10'h010, 10'h001, 10'h001, 10'h004, 10'h002};
  localparam logic [N_P_DEF-1:0] BENCH_INIT = 10'h009;

endpackage

// File: rtl/pn_transition_sequencer_if.sv
// Request/firing bundle between a stimulus driver and the sequencer.
// The driver (master) owns req/hold; the sequencer (slave) owns the rest.
interface pn_transition_sequencer_if #(
  parameter int N_T = 8,
  parameter int N_P = 10
);
  import pn_seq_pkg::*;

  logic [N_T-1:0]          req;
  logic                    hold;
  logic [N_T-1:0]          t_fire;
  logic                    fire_valid;
  logic [idx_w(N_T)-1:0]   fire_idx;
  logic [N_P-1:0]          marking;
  logic [N_T-1:0]          enabled;
  logic                    deadlock;
  logic                    safety_err;

  modport master (
    output req, hold,
    input  t_fire, fire_valid, fire_idx, marking, enabled, deadlock, safety_err
  );

  modport slave (
    input  req, hold,
    output t_fire, fire_valid, fire_idx, marking, enabled, deadlock, safety_err
  );

endinterface

// File: rtl/pn_transition_sequencer_rr_arbiter.sv
// Combinational round-robin picker: first set bit of cand strictly after
// ptr, wrapping modulo N. The caller owns and registers the pointer.
module pn_rr_arbiter
  import pn_seq_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  cand_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] gidx_o,
  output logic          any_o
);

  // Scan ptr+1 .. ptr+N and latch onto the first candidate found.
  always_comb begin
    grant_o = '0;
    gidx_o  = '0;
    any_o   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (int'(ptr_i) + k) % N;
      if (!any_o && cand_i[j]) begin
        any_o      = 1'b1;
        gidx_o     = IW'(j);
        grant_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pn_transition_sequencer.sv
// Stimulus sequencer for the decomposed Petri-net controller. Tracks a
// 1-safe marking, fires at most one requested+enabled transition per cycle
// in round-robin order and flags deadlock and safeness violations.
module pn_transition_sequencer
  import pn_seq_pkg::*;
#(
  parameter int                 N_T       = N_T_DEF,
  parameter int                 N_P       = N_P_DEF,
  parameter logic [N_T*N_P-1:0] PRE       = '0,
  parameter logic [N_T*N_P-1:0] POST      = '0,
  parameter logic [N_P-1:0]     INIT_MARK = N_P'(1)
) (
  input  logic                       clk,
  input  logic                       reset,
  pn_transition_sequencer_if.slave   bus
);

  localparam int IW = idx_w(N_T);
  localparam logic [MAX_BITS-1:0] PRE_X  = MAX_BITS'(PRE);
  localparam logic [MAX_BITS-1:0] POST_X = MAX_BITS'(POST);

  logic [N_T-1:0][N_P-1:0] pre_row, post_row;
  logic [N_T-1:0]          en, cand, grant;
  logic [IW-1:0]           gidx;
  logic                    any;
  logic [N_P-1:0]          pre_g, post_g;

  logic [N_P-1:0] mark_q, mark_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [N_T-1:0] fire_q, fire_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           vld_q, vld_d;
  logic           serr_q, serr_d;

  // Per-transition preset/postset rows and the enabling test. An empty
  // preset would trivially satisfy the subset test, so it is excluded.
  for (genvar i = 0; i < N_T; i++) begin : g_row
    localparam logic [MAX_P-1:0] PRE_R  = row_of(PRE_X, i, N_P);
    localparam logic [MAX_P-1:0] POST_R = row_of(POST_X, i, N_P);
    assign pre_row[i]  = PRE_R[N_P-1:0];
    assign post_row[i] = POST_R[N_P-1:0];
    assign en[i] = (|pre_row[i]) && ((mark_q & pre_row[i]) == pre_row[i]);
  end

  assign cand = bus.req & en;

  pn_rr_arbiter #(.N(N_T), .IW(IW)) u_arb (
    .cand_i  (cand),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .gidx_o  (gidx),
    .any_o   (any)
  );

  assign pre_g  = pre_row[gidx];
  assign post_g = post_row[gidx];

  // Next state: fire the granted transition unless stalled; outputs that
  // describe a pulse fall back to zero on any cycle without a grant.
  always_comb begin
    mark_d = mark_q;
    ptr_d  = ptr_q;
    fire_d = '0;
    idx_d  = '0;
    vld_d  = 1'b0;
    serr_d = serr_q;
    if (!bus.hold && any) begin
      mark_d = (mark_q & ~pre_g) | post_g;
      ptr_d  = gidx;
      fire_d = grant;
      idx_d  = gidx;
      vld_d  = 1'b1;
      // A token landing on an already-marked place breaks 1-safeness.
      if (((mark_q & ~pre_g) & post_g) != '0) serr_d = 1'b1;
    end
  end

  // State registers; reset drops any pulse in flight and rewinds the pointer
  // so T0 is looked at first.
  always_ff @(posedge clk) begin
    if (reset) begin
      mark_q <= INIT_MARK;
      ptr_q  <= IW'(N_T - 1);
      fire_q <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      serr_q <= 1'b0;
    end else begin
      mark_q <= mark_d;
      ptr_q  <= ptr_d;
      fire_q <= fire_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
      serr_q <= serr_d;
    end
  end

  assign bus.t_fire     = fire_q;
  assign bus.fire_valid = vld_q;
  assign bus.fire_idx   = idx_q;
  assign bus.marking    = mark_q;
  assign bus.enabled    = en;
  assign bus.deadlock   = (en == '0);
  assign bus.safety_err = serr_q;

endmodule

// File: tb/tb_pn_transition_sequencer.sv
// Directed bench for the sequencer on the reference net. Firing pulses of
// the main instance are checked by a scoreboard monitor; static state is
// checked inline. Two extra instances cover the unsafe and dead markings.
module tb_pn_transition_sequencer;
  import pn_seq_pkg::*;

  typedef struct {
    logic [2:0] idx;
    logic [9:0] mark;
  } exp_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  exp_t sb[$];
  exp_t mon_e;

  pn_transition_sequencer_if #(.N_T(8), .N_P(10)) a_if ();
  pn_transition_sequencer_if #(.N_T(8), .N_P(10)) b_if ();
  pn_transition_sequencer_if #(.N_T(8), .N_P(10)) c_if ();

  pn_transition_sequencer #(.N_T(8), .N_P(10), .PRE(BENCH_PRE), .POST(BENCH_POST),
    .INIT_MARK(BENCH_INIT)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
  pn_transition_sequencer #(.N_T(8), .N_P(10), .PRE(BENCH_PRE), .POST(BENCH_POST),
    .INIT_MARK(10'h00B)) dut_b (.clk(clk), .reset(reset), .bus(b_if));
  pn_transition_sequencer #(.N_T(8), .N_P(10), .PRE(BENCH_PRE), .POST(BENCH_POST),
    .INIT_MARK(10'h000)) dut_c (.clk(clk), .reset(reset), .bus(c_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input int mark);
    exp_t e;
    e.idx  = 3'(idx);
    e.mark = 10'(mark);
    sb.push_back(e);
  endtask

  // Monitor: every pulse on the main instance must match the next expectation.
  always @(negedge clk) begin
    if (a_if.fire_valid === 1'b1 || (a_if.t_fire !== 8'h00 && a_if.t_fire !== 8'hxx)) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: got t_fire 0x%0h idx %0d, expected none",
                 a_if.t_fire, a_if.fire_idx);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_idx",   32'(a_if.fire_idx),   32'(mon_e.idx));
        chk("pulse_onehot", 32'(a_if.t_fire),    32'(8'd1 << mon_e.idx));
        chk("pulse_valid", 32'(a_if.fire_valid), 32'd1);
        chk("pulse_mark",  32'(a_if.marking),    32'(mon_e.mark));
      end
    end
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    a_if.req = '0; a_if.hold = 1'b0;
    b_if.req = '0; b_if.hold = 1'b0;
    c_if.req = '0; c_if.hold = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset / idle state
    chk("rst_mark",    32'(a_if.marking),    32'h009);
    chk("rst_tfire",   32'(a_if.t_fire),     32'h0);
    chk("rst_valid",   32'(a_if.fire_valid), 32'h0);
    chk("rst_idx",     32'(a_if.fire_idx),   32'h0);
    chk("rst_enabled", 32'(a_if.enabled),    32'h13);
    chk("rst_dead",    32'(a_if.deadlock),   32'h0);
    chk("rst_serr",    32'(a_if.safety_err), 32'h0);

    // Single request for T0
    push(0, 'h00A);
    a_if.req = 8'h01;
    tick();
    a_if.req = 8'h00;
    chk("s2_enabled", 32'(a_if.enabled), 32'h14);
    tick();
    chk("s2_no_refire", 32'(a_if.t_fire),  32'h0);
    chk("s2_mark_hold", 32'(a_if.marking), 32'h00A);

    // All requests held: T0, T2, T4, T5, T0
    reset = 1'b1; tick(); reset = 1'b0;
    chk("s3_mark0", 32'(a_if.marking), 32'h009);
    push(0, 'h00A); push(2, 'h009); push(4, 'h011); push(5, 'h009); push(0, 'h00A);
    a_if.req = 8'hFF;
    repeat (5) tick();
    a_if.req = 8'h00;
    tick(); tick();
    chk("s3_drained", 32'(sb.size()), 32'd0);

    // Hold for three cycles after the T2 pulse; resume with T4
    reset = 1'b1; tick(); reset = 1'b0;
    push(0, 'h00A); push(2, 'h009);
    a_if.req = 8'hFF;
    tick(); tick();
    a_if.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s4_hold_tfire", 32'(a_if.t_fire),     32'h0);
      chk("s4_hold_valid", 32'(a_if.fire_valid), 32'h0);
      chk("s4_hold_mark",  32'(a_if.marking),    32'h009);
      chk("s4_hold_dead",  32'(a_if.deadlock),   32'h0);
    end
    a_if.hold = 1'b0;
    push(4, 'h011);
    tick();
    a_if.req = 8'h00;
    tick();
    chk("s4_drained", 32'(sb.size()), 32'd0);

    // Reset mid-stream drops the in-flight pulse; T0 goes first afterwards
    reset = 1'b1; tick(); reset = 1'b0;
    push(0, 'h00A); push(2, 'h009);
    a_if.req = 8'hFF;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("s6_rst_tfire", 32'(a_if.t_fire),     32'h0);
    chk("s6_rst_valid", 32'(a_if.fire_valid), 32'h0);
    chk("s6_rst_mark",  32'(a_if.marking),    32'h009);
    chk("s6_rst_serr",  32'(a_if.safety_err), 32'h0);
    reset = 1'b0;
    push(0, 'h00A);
    tick();
    a_if.req = 8'h00;
    tick();
    chk("s6_drained", 32'(sb.size()), 32'd0);

    // Unsafe marking 0x00B: firing T0 puts a second token on p1
    chk("s5_pre_mark", 32'(b_if.marking),    32'h00B);
    chk("s5_pre_serr", 32'(b_if.safety_err), 32'h0);
    b_if.req = 8'h01;
    tick();
    b_if.req = 8'h00;
    chk("s5_tfire", 32'(b_if.t_fire),     32'h01);
    chk("s5_idx",   32'(b_if.fire_idx),   32'h0);
    chk("s5_valid", 32'(b_if.fire_valid), 32'h1);
    chk("s5_mark",  32'(b_if.marking),    32'h00A);
    chk("s5_serr",  32'(b_if.safety_err), 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("s5_serr_sticky", 32'(b_if.safety_err), 32'h1);
      chk("s5_idle_tfire",  32'(b_if.t_fire),     32'h0);
    end

    // Empty marking: dead, nothing fires whatever is requested
    chk("dead_flag",    32'(c_if.deadlock), 32'h1);
    chk("dead_enabled", 32'(c_if.enabled),  32'h0);
    c_if.req = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dead_tfire", 32'(c_if.t_fire),     32'h0);
      chk("dead_valid", 32'(c_if.fire_valid), 32'h0);
      chk("dead_mark",  32'(c_if.marking),    32'h0);
    end
    c_if.req = 8'h00;

    tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
